// File: rtl/tenbaset_pkg.sv
// Shared types and default timing constants for the 10BASE-T transmit scheduler.
// Defaults assume a 60 MHz clock and a 20 MHz half-bit rate.
package tenbaset_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_NLP   = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  localparam logic [1:0] SEL_IDLE  = 2'd0;
  localparam logic [1:0] SEL_FRAME = 2'd1;
  localparam logic [1:0] SEL_NLP   = 2'd2;

  localparam int DEF_CLK_DIV    = 3;
  localparam int DEF_FRAME_MAX  = 1212;
  localparam int DEF_NLP_LEN    = 56;
  localparam int DEF_NLP_PERIOD = 200000;
  localparam int DEF_IFG_TICKS  = 192;

  localparam int NLP_TMR_W = 18;

  // Requested lengths above the burst limit are sent truncated, never rejected.
  function automatic logic [10:0] clamp_len(input logic [10:0] len,
                                            input logic [10:0] max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/tenbaset_tick_gen.sv
// Half-bit tick divider: counts 0..CLK_DIV-1 and flags the last count with a
// registered one-cycle pulse.
module tenbaset_tick_gen #(
  parameter int CLK_DIV = 3
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // NOTE: combinational helpers get a value on every path, so no latch is inferred.
  always_comb begin
    cnt_nxt = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
  end

  // tick is registered from the next count so it is high exactly while cnt==CNT_LAST.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      tick <= (cnt_nxt == CNT_LAST);
    end
  end

endmodule

// File: rtl/tenbaset_tx_scheduler.sv
// 10BASE-T transmit sequencer: arbitrates frame bursts against normal link
// pulses, enforces the inter-frame gap and publishes burst select and index.
module tenbaset_tx_scheduler
  import tenbaset_pkg::*;
#(
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int FRAME_MAX  = DEF_FRAME_MAX,
  parameter int NLP_LEN    = DEF_NLP_LEN,
  parameter int NLP_PERIOD = DEF_NLP_PERIOD,
  parameter int IFG_TICKS  = DEF_IFG_TICKS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_req,
  input  logic [10:0] frame_len,
  output logic        tick,
  output logic [1:0]  sel,
  output logic [10:0] bit_idx,
  output logic        line_en,
  output logic        frame_grant,
  output logic        frame_done
);

  localparam int IDX_W = (FRAME_MAX > 1) ? $clog2(FRAME_MAX) : 1;
  localparam int GAP_W = $clog2(IFG_TICKS + 1);

  localparam logic [GAP_W-1:0]     GAP_LAST    = GAP_W'(IFG_TICKS - 1);
  localparam logic [NLP_TMR_W-1:0] NLP_DUE_VAL = NLP_TMR_W'(NLP_PERIOD);
  localparam logic [IDX_W-1:0]     NLP_LAST    = IDX_W'(NLP_LEN - 1);
  localparam logic [10:0]          LEN_LIMIT   = 11'(FRAME_MAX);

  state_t               state;
  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     last_idx;
  logic [GAP_W-1:0]     gap_cnt;
  logic [NLP_TMR_W-1:0] nlp_tmr;
  logic                 nlp_due;

  tenbaset_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign nlp_due = (nlp_tmr == NLP_DUE_VAL);
  assign bit_idx = 11'(idx);

  // NOTE: all state here is updated with non-blocking assignments so every
  // right-hand side sees the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      sel         <= SEL_IDLE;
      line_en     <= 1'b0;
      idx         <= '0;
      last_idx    <= '0;
      gap_cnt     <= '0;
      nlp_tmr     <= '0;
      frame_grant <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_grant <= 1'b0;
      frame_done  <= 1'b0;

      if (tick) begin
        // Silence timer saturates at the NLP period; burst ends override below.
        if ((state == ST_IDLE || state == ST_GAP) && !nlp_due)
          nlp_tmr <= nlp_tmr + 1'b1;

        unique case (state)
          ST_IDLE: begin
            idx <= '0;
            if (nlp_due) begin
              state    <= ST_NLP;
              sel      <= SEL_NLP;
              line_en  <= 1'b1;
              last_idx <= NLP_LAST;
              nlp_tmr  <= '0;
            end else if (frame_req) begin
              frame_grant <= 1'b1;
              if (frame_len == '0) begin
                // Empty frame: acknowledge and still pay the full gap.
                frame_done <= 1'b1;
                state      <= ST_GAP;
                gap_cnt    <= '0;
                nlp_tmr    <= '0;
              end else begin
                state    <= ST_FRAME;
                sel      <= SEL_FRAME;
                line_en  <= 1'b1;
                last_idx <= IDX_W'(clamp_len(frame_len, LEN_LIMIT) - 11'd1);
              end
            end
          end

          ST_FRAME, ST_NLP: begin
            if (idx == last_idx) begin
              frame_done <= (state == ST_FRAME);
              state      <= ST_GAP;
              sel        <= SEL_IDLE;
              line_en    <= 1'b0;
              idx        <= '0;
              gap_cnt    <= '0;
              nlp_tmr    <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end

          ST_GAP: begin
            if (gap_cnt == GAP_LAST) state   <= ST_IDLE;
            else                     gap_cnt <= gap_cnt + 1'b1;
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/tenbaset_tx_scheduler.md
# tenbaset_tx_scheduler

Sequencing controller for the 10BASE-T transmit path on the ice4pi board. It derives the half-bit tick from the PLL clock and owns the transmit line. It interleaves Manchester-encoded frame bursts from a single requester with periodic normal link pulses (NLP), and enforces the inter-frame gap. It emits a burst-select code and a half-bit index; the downstream bit source uses these to pick the next `tx` bit and drive `ce0`.

## Interface

Parameters:
- `CLK_DIV`, 3: clock cycles per half-bit tick (60 MHz → 20 MHz).
- `FRAME_MAX`, 1212: maximum frame burst length in half-bits.
- `NLP_LEN`, 56: NLP burst length in half-bits.
- `NLP_PERIOD`, 200000: ticks of line silence before an NLP is due.
- `IFG_TICKS`, 192: idle ticks after every burst (9.6 µs).

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: 60 MHz PLL clock.
- `rst` in 1: synchronous, active-high reset.
- `frame_req` in 1: level; held high until `frame_grant`.
- `frame_len` in 11: burst length in half-bits; sampled on the grant cycle.
- `tick` out 1: one-cycle pulse per half-bit period.
- `sel` out 2: 0 idle, 1 frame, 2 NLP.
- `bit_idx` out 11: half-bit index within the current burst.
- `line_en` out 1: high while `sel` is nonzero.
- `frame_grant` out 1: one-cycle pulse on frame start.
- `frame_done` out 1: one-cycle pulse on the last frame half-bit.

## Operation

- States:
  - IDLE: line silent.
  - FRAME: frame burst in progress.
  - NLP: link pulse in progress.
  - GAP: inter-frame gap countdown.
- The state machine changes state, advances `bit_idx` and changes the timers only on cycles with `tick`=1.
- Divider:
  - Counts 0..CLK_DIV-1.
  - `tick` is asserted when the count equals CLK_DIV-1.
- NLP timer:
  - 18 bits.
  - Increments each tick in IDLE and GAP, saturating at NLP_PERIOD.
  - Clears when a FRAME or NLP burst ends.
  - `nlp_due` = (timer == NLP_PERIOD); it stays set until an NLP starts.
- IDLE on tick:
  - If `nlp_due`: go to NLP with `bit_idx`=0.
  - Else if `frame_req`: go to FRAME, pulse `frame_grant`, latch the length, `bit_idx`=0.
  - When both are true, NLP wins; `frame_req` stays pending.
- Length rules:
  - `frame_len`=0: `frame_grant` and `frame_done` pulse together; go to GAP with no line activity.
  - `frame_len`>FRAME_MAX: clamp to FRAME_MAX.
- FRAME:
  - `bit_idx` increments each tick.
  - On the tick where `bit_idx`=len-1: pulse `frame_done` and go to GAP.
- NLP: same as FRAME with length NLP_LEN; no `frame_done`.
- GAP:
  - Counts IFG_TICKS ticks, then goes to IDLE.
  - Requests are not granted during GAP.
- Dropping `frame_req` before grant: legal, and withdraws the request.
- Reset:
  - All outputs 0, state IDLE, divider 0, NLP timer 0, gap counter 0.
  - Reset mid-burst aborts the burst immediately (line drops the next cycle) and produces no `frame_done`.

## Timing

- Outputs are registered.
- `sel`, `bit_idx` and `line_en` update in the cycle after the deciding tick, and hold for CLK_DIV cycles per half-bit.
- `frame_grant` and `frame_done` are high for exactly one clock, in the cycle after the tick that decides them.
- First tick: cycle CLK_DIV after `rst` deasserts.
- Grant latency: at most one tick period from `frame_req` rising in IDLE (no pending NLP).
- Back-to-back frames: the minimum spacing between the last active half-bit and the next first half-bit is IFG_TICKS+1 ticks.
- Widths:
  - `bit_idx` is `$clog2(FRAME_MAX)` bits, zero-extended to 11.
  - The gap counter is `$clog2(IFG_TICKS+1)` bits.
  - No counter wraps; all counters saturate or reload.

## Structure

- Package `tenbaset_pkg`:
  - State enum (IDLE/FRAME/NLP/GAP).
  - `sel` encodings: SEL_IDLE=0, SEL_FRAME=1, SEL_NLP=2.
  - Default constants: CLK_DIV, FRAME_MAX, NLP_LEN, NLP_PERIOD, IFG_TICKS.
- Sub-module `tenbaset_tick_gen`: parameterised divider producing `tick`, cleared by `rst`. The rest of the logic stays in a single FSM process.

## Test plan

Bench parameters: CLK_DIV=3, FRAME_MAX=16, NLP_LEN=3, NLP_PERIOD=20, IFG_TICKS=4.

- Reset, no request:
  - First `tick` at cycle 3.
  - `sel`=2 for 3 ticks after tick 21.
  - Then 4 gap ticks and IDLE.
  - NLP recurs every 20 idle ticks thereafter.
- `frame_req` with `frame_len`=5 while idle:
  - One-cycle `frame_grant`.
  - `bit_idx` runs 0..4 with `sel`=1, each value held 3 cycles.
  - `frame_done` on the tick of index 4.
  - `line_en` low for 4 ticks afterwards.
- `frame_req` and `nlp_due` on the same tick:
  - NLP runs first (3 ticks), then 4 gap ticks.
  - Then the frame is granted.
  - The NLP timer clears after the frame ends.
- `frame_len`=0: grant and done in the same cycle, `line_en` never rises, GAP is entered. `frame_len`=40: 16 half-bits sent.
- Continuous `frame_req` with length 2:
  - Grants exactly IFG_TICKS+1 ticks after each `frame_done`.
  - No NLP while the timer keeps clearing.
- `rst` asserted at `bit_idx`=3 of a frame:
  - Next cycle all outputs are 0 and no `frame_done`.
  - Next tick 3 cycles after release.
